// File: rtl/riscv_core_decode_queue_if.sv
// ----------------------------------------------------------------------------
// riscv_core_decode_queue_if
// Handshake bundle between fetch (IF), the decode queue and the decoder (ID).
// Signal names keep their direction prefix as seen from the queue.
//   slave  : queue view  - accepts IF push, presents ID head
//   master : environment - drives IF push, consumes ID head
// Fetch side : i_if_valid, o_if_ready, i_if_instr, i_if_pc, i_if_illegal
// Decode side: o_id_valid, i_id_ready, o_id_instr, o_id_pc, o_id_class,
//              o_id_illegal, o_id_ecall, o_id_ebreak, o_id_mret, o_id_csr_wen
// ----------------------------------------------------------------------------
interface riscv_core_decode_queue_if #(
   parameter int PC_W = 64
);
   logic            i_if_valid;
   logic            o_if_ready;
   logic [31:0]     i_if_instr;
   logic [PC_W-1:0] i_if_pc;
   logic            i_if_illegal;

   logic            o_id_valid;
   logic            i_id_ready;
   logic [31:0]     o_id_instr;
   logic [PC_W-1:0] o_id_pc;
   logic [3:0]      o_id_class;
   logic            o_id_illegal;
   logic            o_id_ecall;
   logic            o_id_ebreak;
   logic            o_id_mret;
   logic            o_id_csr_wen;

   modport slave (
      input  i_if_valid, i_if_instr, i_if_pc, i_if_illegal, i_id_ready,
      output o_if_ready, o_id_valid, o_id_instr, o_id_pc, o_id_class,
             o_id_illegal, o_id_ecall, o_id_ebreak, o_id_mret, o_id_csr_wen
   );

   modport master (
      output i_if_valid, i_if_instr, i_if_pc, i_if_illegal, i_id_ready,
      input  o_if_ready, o_id_valid, o_id_instr, o_id_pc, o_id_class,
             o_id_illegal, o_id_ecall, o_id_ebreak, o_id_mret, o_id_csr_wen
   );
endinterface

// File: rtl/riscv_core_decode_queue.sv
// ----------------------------------------------------------------------------
// riscv_core_decode_queue
// In-order decoupling FIFO between IF and ID. Each instruction is pre-decoded
// (opcode class, illegal, ecall/ebreak/mret, csr_wen) as it is pushed and the
// result is stored alongside it, so the head is presented straight from
// storage through a mux.
// Ports:
//   i_clk, i_rst_n (async, active low), i_flush (sync, beats push/pop)
//   q       : riscv_core_decode_queue_if.slave (IF push / ID pop handshake)
//   o_count : current occupancy, 0..DEPTH
// Optional feature: DECODE_QUEUE_BYPASS_EN - when the queue is empty and
//   decode is ready, the fetched instruction is forwarded combinationally and
//   never stored. Without it the minimum latency is one cycle and o_id_valid
//   comes purely from the occupancy register.
// ----------------------------------------------------------------------------
module riscv_core_decode_queue #(
   parameter int DEPTH = 4,
   parameter int PC_W  = 64
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_flush,
   riscv_core_decode_queue_if.slave  q,
   output logic [$clog2(DEPTH):0]    o_count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [31:0]     instr;
      logic [PC_W-1:0] pc;
      logic [3:0]      cls;
      logic            illegal;
      logic            ecall;
      logic            ebreak;
      logic            mret;
      logic            csr_wen;
   } entry_t;

   function automatic entry_t predecode(input logic [31:0] instr,
                                        input logic [PC_W-1:0] pc,
                                        input logic fault);
      entry_t     e;
      logic [2:0] f3;
      e        = '0;
      e.instr  = instr;
      e.pc     = pc;
      f3       = instr[14:12];
      case (instr[6:0])
         7'b0000011: e.cls = 4'd0;
         7'b0100011: e.cls = 4'd1;
         7'b0110011: e.cls = 4'd2;
         7'b0010011: e.cls = 4'd3;
         7'b0111011: e.cls = 4'd4;
         7'b0011011: e.cls = 4'd5;
         7'b1100011: e.cls = 4'd6;
         7'b1101111: e.cls = 4'd7;
         7'b1100111: e.cls = 4'd8;
         7'b0110111: e.cls = 4'd9;
         7'b0010111: e.cls = 4'd10;
         7'b1110011: e.cls = 4'd11;
         7'b0101111: e.cls = 4'd12;
         7'b0001111: e.cls = 4'd13;
         default:    e.cls = 4'd15;
      endcase
      e.illegal = (e.cls == 4'd15) | (instr[1:0] != 2'b11) | fault;
      // Set/clear forms (funct3[1]=1) with rs1/uimm = 0 are pure CSR reads.
      e.csr_wen = (e.cls == 4'd11) & (f3 != 3'b000)
                & ~(f3[1] & (instr[19:15] == 5'd0)) & ~e.illegal;
      e.ecall   = (instr == 32'h0000_0073) & ~e.illegal;
      e.ebreak  = (instr == 32'h0010_0073) & ~e.illegal;
      e.mret    = (instr == 32'h3020_0073) & ~e.illegal;
      return e;
   endfunction

   entry_t             mem_q [DEPTH];
   entry_t             mem_d [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;

   entry_t             in_entry;
   entry_t             out_entry;
   logic               full, empty;
   logic               bypass;
   logic               push, pop;

   assign in_entry = predecode(q.i_if_instr, q.i_if_pc, q.i_if_illegal);
   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);

`ifdef DECODE_QUEUE_BYPASS_EN
   // Zero-latency path: consumed in the same cycle, so nothing is stored.
   assign bypass = empty & q.i_if_valid & q.i_id_ready & ~i_flush;
`else
   assign bypass = 1'b0;
`endif

   // Ready is a function of occupancy only: a full queue refuses a push even
   // when the head is popped in the same cycle.
   assign push = q.i_if_valid & ~full & ~bypass;
   assign pop  = ~empty & q.i_id_ready;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (i_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = in_entry;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      end
   end

   // Payload is zeroed whenever the head is not valid.
   always_comb begin
      out_entry = '0;
      if (bypass)      out_entry = in_entry;
      else if (!empty) out_entry = mem_q[rd_ptr_q];
   end

   assign q.o_if_ready   = ~full;
   assign q.o_id_valid   = ~empty | bypass;
   assign q.o_id_instr   = out_entry.instr;
   assign q.o_id_pc      = out_entry.pc;
   assign q.o_id_class   = out_entry.cls;
   assign q.o_id_illegal = out_entry.illegal;
   assign q.o_id_ecall   = out_entry.ecall;
   assign q.o_id_ebreak  = out_entry.ebreak;
   assign q.o_id_mret    = out_entry.mret;
   assign q.o_id_csr_wen = out_entry.csr_wen;
   assign o_count        = count_q;
endmodule

// File: tb/tb_riscv_core_decode_queue.sv
// ----------------------------------------------------------------------------
// tb_riscv_core_decode_queue
// Scoreboarded bench: accepted pushes are queued with their fetch data, the
// head is checked against the front entry every cycle, and a pop retires it.
// Directed checks cover reset, fill/full, pre-decode cases, flush and
// asynchronous reset.
// ----------------------------------------------------------------------------
module tb_riscv_core_decode_queue;
   localparam int DEPTH = 4;
   localparam int PC_W  = 64;

   typedef struct {
      logic [31:0]     instr;
      logic [PC_W-1:0] pc;
      logic            fault;
   } sb_t;

   logic                   clk   = 1'b0;
   logic                   rst_n = 1'b0;
   logic                   flush = 1'b0;
   logic [$clog2(DEPTH):0] count;

   int  n_vec = 0;
   int  n_err = 0;
   int  mcount = 0;
   sb_t sb[$];

   riscv_core_decode_queue_if #(.PC_W(PC_W)) bus ();

   riscv_core_decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_flush (flush),
      .q       (bus.slave),
      .o_count (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h @%0t", tag, obs, exp, $time);
      end
   endtask

   // Reference pre-decode: {class[3:0], illegal, ecall, ebreak, mret, csr_wen}
   function automatic logic [8:0] ref_pd(input logic [31:0] ins, input logic f);
      logic [3:0] c;
      logic       ill, w;
      logic [2:0] f3;
      f3 = ins[14:12];
      case (ins[6:0])
         7'h03: c = 4'd0;   7'h23: c = 4'd1;   7'h33: c = 4'd2;
         7'h13: c = 4'd3;   7'h3B: c = 4'd4;   7'h1B: c = 4'd5;
         7'h63: c = 4'd6;   7'h6F: c = 4'd7;   7'h67: c = 4'd8;
         7'h37: c = 4'd9;   7'h17: c = 4'd10;  7'h73: c = 4'd11;
         7'h2F: c = 4'd12;  7'h0F: c = 4'd13;
         default: c = 4'd15;
      endcase
      ill = (c == 4'd15) || (ins[1:0] != 2'b11) || f;
      w   = (c == 4'd11) && (f3 != 3'd0) &&
            !((f3 == 3'd2 || f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) && ins[19:15] == 5'd0);
      if (ill) return {c, 5'b10000};
      return {c, 1'b0, ins == 32'h73, ins == 32'h0010_0073, ins == 32'h3020_0073, w};
   endfunction

   function automatic logic [8:0] got_flags();
      return {bus.o_id_class, bus.o_id_illegal, bus.o_id_ecall, bus.o_id_ebreak,
              bus.o_id_mret, bus.o_id_csr_wen};
   endfunction

   // Scoreboard monitor: sample mid-cycle with inputs stable.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
         mcount = 0;
      end else begin
         bit  byp, pop, push;
         sb_t e;
         byp = 1'b0;
`ifdef DECODE_QUEUE_BYPASS_EN
         byp = (mcount == 0) && bus.i_if_valid && bus.i_id_ready && !flush;
`endif
         chk("count", 64'(count), 64'(mcount));
         chk("if_ready", 64'(bus.o_if_ready), 64'(mcount != DEPTH));
         if (byp) begin
            chk("byp_valid", 64'(bus.o_id_valid), 64'd1);
            chk("byp_instr", 64'(bus.o_id_instr), 64'(bus.i_if_instr));
            chk("byp_flags", 64'(got_flags()), 64'(ref_pd(bus.i_if_instr, bus.i_if_illegal)));
         end else if (mcount == 0) begin
            chk("idle_valid", 64'(bus.o_id_valid), 64'd0);
            chk("idle_payload", {bus.o_id_instr, 23'd0, got_flags()} | bus.o_id_pc, 64'd0);
         end else begin
            chk("head_valid", 64'(bus.o_id_valid), 64'd1);
            chk("head_instr", 64'(bus.o_id_instr), 64'(sb[0].instr));
            chk("head_pc", bus.o_id_pc, sb[0].pc);
            chk("head_flags", 64'(got_flags()), 64'(ref_pd(sb[0].instr, sb[0].fault)));
         end
         if (flush) begin
            sb.delete();
            mcount = 0;
         end else begin
            pop  = (mcount != 0) && bus.i_id_ready;
            push = bus.i_if_valid && (mcount != DEPTH) && !byp;
            if (pop) void'(sb.pop_front());
            if (push) begin
               e.instr = bus.i_if_instr;
               e.pc    = bus.i_if_pc;
               e.fault = bus.i_if_illegal;
               sb.push_back(e);
            end
            mcount = mcount + int'(push) - int'(pop);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] pc, input logic f);
      bus.i_if_valid   = v;
      bus.i_if_instr   = ins;
      bus.i_if_pc      = pc;
      bus.i_if_illegal = f;
   endtask

   // Push one instruction into an empty queue, check stored pre-decode, pop it.
   task automatic pd_case(input string tag, input logic [31:0] ins, input logic f,
                          input logic [8:0] exp);
      bus.i_id_ready = 1'b0;
      drive(1'b1, ins, 64'h2000, f);
      step();
      drive(1'b0, 32'h0, 64'h0, 1'b0);
      chk({tag, "_valid"}, 64'(bus.o_id_valid), 64'd1);
      chk({tag, "_flags"}, 64'(got_flags()), 64'(exp));
      bus.i_id_ready = 1'b1;
      step();
      bus.i_id_ready = 1'b0;
   endtask

   logic [31:0] pool [8] = '{32'h0000_0013, 32'h0000_0073, 32'h3000_2573, 32'h3000_1073,
                             32'hFFFF_FFFF, 32'h0010_0073, 32'h3020_0073, 32'h0000_006F};

   initial begin
      drive(1'b0, 32'h0, 64'h0, 1'b0);
      bus.i_id_ready = 1'b0;
      #1;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_id_valid", 64'(bus.o_id_valid), 64'd0);
      chk("rst_if_ready", 64'(bus.o_if_ready), 64'd1);
      chk("rst_payload", 64'(bus.o_id_instr) | bus.o_id_pc, 64'd0);
      step();
      step();
      rst_n = 1'b1;
      step();

      // First push: visible one cycle later
      drive(1'b1, 32'h0000_0013, 64'h1000, 1'b0);
      step();
      drive(1'b0, 32'h0, 64'h0, 1'b0);
      chk("first_valid", 64'(bus.o_id_valid), 64'd1);
      chk("first_class", 64'(bus.o_id_class), 64'd3);
      chk("first_illegal", 64'(bus.o_id_illegal), 64'd0);
      chk("first_count", 64'(count), 64'd1);
      bus.i_id_ready = 1'b1;
      step();
      bus.i_id_ready = 1'b0;

      // Fill to DEPTH, then a fifth push must be refused
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 32'h0000_0013 | (32'(i + 1) << 7), 64'(4 * i), 1'b0);
         step();
      end
      chk("full_count", 64'(count), 64'd4);
      chk("full_if_ready", 64'(bus.o_if_ready), 64'd0);
      drive(1'b1, 32'h0000_0093, 64'h10, 1'b0);
      step();
      chk("full_5th_count", 64'(count), 64'd4);
      // Full + pop + push attempt: one pop only
      bus.i_id_ready = 1'b1;
      step();
      chk("full_pop_count", 64'(count), 64'd3);
      drive(1'b0, 32'h0, 64'h0, 1'b0);
      chk("drain_pc1", bus.o_id_pc, 64'h4);
      step();
      chk("drain_pc2", bus.o_id_pc, 64'h8);
      step();
      chk("drain_pc3", bus.o_id_pc, 64'hC);
      step();
      bus.i_id_ready = 1'b0;

      pd_case("ecall",  32'h0000_0073, 1'b0, {4'd11, 5'b01000});
      pd_case("csrrs0", 32'h3000_2573, 1'b0, {4'd11, 5'b00000});
      pd_case("csrrw",  32'h3000_1073, 1'b0, {4'd11, 5'b00001});
      pd_case("allone", 32'hFFFF_FFFF, 1'b0, {4'd15, 5'b10000});
      pd_case("fault",  32'h0000_0013, 1'b1, {4'd3,  5'b10000});
      pd_case("ebreak", 32'h0010_0073, 1'b0, {4'd11, 5'b00100});
      pd_case("mret",   32'h3020_0073, 1'b0, {4'd11, 5'b00010});
      pd_case("csrrci", 32'h3000_F073, 1'b0, {4'd11, 5'b00001});

      // Flush at count 3 with a simultaneous push
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h0000_0013, 64'h3000 + 64'(4 * i), 1'b0);
         step();
      end
      chk("pre_flush_count", 64'(count), 64'd3);
      flush = 1'b1;
      drive(1'b1, 32'h0000_0033, 64'h300C, 1'b0);
      step();
      flush = 1'b0;
      drive(1'b0, 32'h0, 64'h0, 1'b0);
      chk("flush_count", 64'(count), 64'd0);
      chk("flush_valid", 64'(bus.o_id_valid), 64'd0);

`ifdef DECODE_QUEUE_BYPASS_EN
      bus.i_id_ready = 1'b1;
      drive(1'b1, 32'h0000_0073, 64'h4000, 1'b0);
      #1;
      chk("byp_same_cycle_valid", 64'(bus.o_id_valid), 64'd1);
      chk("byp_count", 64'(count), 64'd0);
      step();
      chk("byp_after_count", 64'(count), 64'd0);
      drive(1'b0, 32'h0, 64'h0, 1'b0);
      bus.i_id_ready = 1'b0;
`endif

      // Random traffic with occasional flush
      for (int i = 0; i < 400; i++) begin
         logic [31:0] ins;
         ins = ($urandom_range(0, 3) == 0) ? $urandom() : pool[$urandom_range(0, 7)];
         drive(1'($urandom_range(0, 1)), ins, 64'h8000 + 64'(4 * i),
               ($urandom_range(0, 7) == 0));
         bus.i_id_ready = 1'($urandom_range(0, 2) != 0 ? $urandom_range(0, 1) : 0);
         flush = ($urandom_range(0, 19) == 0);
         step();
      end
      flush = 1'b0;

      // Asynchronous reset mid-stream
      bus.i_id_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 32'h0000_0013, 64'h5000 + 64'(4 * i), 1'b0);
         step();
      end
      drive(1'b0, 32'h0, 64'h0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_count", 64'(count), 64'd0);
      chk("async_rst_valid", 64'(bus.o_id_valid), 64'd0);
      step();
      step();
      rst_n = 1'b1;
      step();
      chk("post_rst_count", 64'(count), 64'd0);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
